// File: rtl/mips_scp_pkg.sv
// Shared definitions for the syscall sequencer: syscall codes and the FSM state encoding.
package mips_scp_pkg;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR = 32'd4;
  localparam logic [31:0] SYS_SBRK      = 32'd9;
  localparam logic [31:0] SYS_EXIT      = 32'd10;

  typedef enum logic [2:0] {
    StIdle,
    StIntOut,
    StRdReq,
    StRdWait,
    StEmit,
    StDone,
    StHalt
  } scp_state_e;

endpackage

// File: rtl/syscall_sequencer_if.sv
// Signal bundle between the syscall sequencer and its environment (core control, shared
// memory read port, console sinks).
//   slave  : the sequencer side (serves syscalls, drives memory requests and console data)
//   master : the environment side (core, memory mux, console sink)
interface syscall_sequencer_if;
  // Core control
  logic        sys_req;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        stall;
  logic        sys_done;
  logic        v0_we;
  logic [31:0] v0_wdata;
  // Shared memory read port
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  // Console sinks
  logic        chr_valid;
  logic [7:0]  chr_data;
  logic        chr_ready;
  logic        int_valid;
  logic [31:0] int_data;
  logic        int_ready;
  // Status
  logic [31:0] heap_ptr;
  logic        halted;

  modport slave (
    input  sys_req, v0, a0, mem_gnt, mem_rdata, chr_ready, int_ready,
    output stall, sys_done, v0_we, v0_wdata, mem_req, mem_addr, chr_valid, chr_data,
           int_valid, int_data, heap_ptr, halted
  );

  modport master (
    output sys_req, v0, a0, mem_gnt, mem_rdata, chr_ready, int_ready,
    input  stall, sys_done, v0_we, v0_wdata, mem_req, mem_addr, chr_valid, chr_data,
           int_valid, int_data, heap_ptr, halted
  );
endinterface

// File: rtl/sys_heap_alloc.sv
// Heap bump allocator for sbrk.
//   clk_i, reset_i : clock, synchronous active-high reset
//   req_bytes_i    : requested size ($a0), rounded up to a whole word
//   commit_i       : apply the allocation this cycle (only takes effect if it fits)
//   heap_ptr_o     : current heap break
//   result_o       : sbrk return value: old break if it fits, else all-ones
module sys_heap_alloc #(
  parameter logic [31:0] HEAP_BASE = 32'h1000_0000,
  parameter logic [31:0] HEAP_SIZE = 32'h0000_00fc
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] req_bytes_i,
  input  logic        commit_i,
  output logic [31:0] heap_ptr_o,
  output logic [31:0] result_o
);

  localparam logic [32:0] HeapLimit = {1'b0, HEAP_BASE} + {1'b0, HEAP_SIZE};

  logic [31:0] heap_q, heap_d;
  logic [31:0] req_rounded;
  logic [32:0] heap_sum;
  logic        fits;

  always_comb begin
    // 32-bit wrap of the rounding is deliberately ignored.
    req_rounded = (req_bytes_i + 32'd3) & ~32'd3;
    // 33-bit sum so a request past the top of the address space never looks like a fit.
    heap_sum    = {1'b0, heap_q} + {1'b0, req_rounded};
    fits        = (heap_sum <= HeapLimit);
    result_o    = fits ? heap_q : 32'hFFFF_FFFF;
    heap_d      = (commit_i && fits) ? heap_sum[31:0] : heap_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      heap_q <= HEAP_BASE;
    end else begin
      heap_q <= heap_d;
    end
  end

  assign heap_ptr_o = heap_q;

endmodule

// File: rtl/syscall_sequencer.sv
// Multi-cycle syscall engine: print-int (1), print-string (4), sbrk (9), exit (10).
// Stalls the core while a syscall runs, reads string bytes through the shared memory port,
// streams characters/integers to the console and owns the heap break.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of syscall_sequencer_if (core control, memory port, console)
module syscall_sequencer
  import mips_scp_pkg::*;
#(
  parameter logic [31:0] HEAP_BASE = 32'h1000_0000,
  parameter logic [31:0] HEAP_SIZE = 32'h0000_00fc,
  parameter int unsigned MAX_STR   = 256
) (
  input logic                clk,
  input logic                reset,
  syscall_sequencer_if.slave bus
);

  localparam int unsigned CntW = $clog2(MAX_STR + 1);

  scp_state_e      state_q, state_d;
  logic [31:0]     code_q, code_d;
  logic [31:0]     ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     word_q, word_d;

  logic [CntW-1:0] cnt_inc;
  logic [7:0]      cur_byte;
  logic            heap_commit;
  logic [31:0]     heap_result;
  logic            sys_done;
  logic            v0_we;
  logic            mem_req;
  logic [31:0]     mem_addr;
  logic            chr_valid;
  logic [7:0]      chr_data;
  logic            int_valid;
  logic [31:0]     int_data;

  sys_heap_alloc #(
    .HEAP_BASE (HEAP_BASE),
    .HEAP_SIZE (HEAP_SIZE)
  ) u_heap (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_bytes_i (bus.a0),
    .commit_i    (heap_commit),
    .heap_ptr_o  (bus.heap_ptr),
    .result_o    (heap_result)
  );

  // Strings are big-endian within a word: byte offset 0 is the most significant byte.
  always_comb begin
    cur_byte = word_q[31:24];
    unique case (ptr_q[1:0])
      2'd0: cur_byte = word_q[31:24];
      2'd1: cur_byte = word_q[23:16];
      2'd2: cur_byte = word_q[15:8];
      2'd3: cur_byte = word_q[7:0];
      default: cur_byte = word_q[31:24];
    endcase
  end

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    heap_commit = 1'b0;
    sys_done    = 1'b0;
    v0_we       = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    chr_valid   = 1'b0;
    chr_data    = '0;
    int_valid   = 1'b0;
    int_data    = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.sys_req) begin
          code_d = bus.v0;
          case (bus.v0)
            SYS_PRINT_INT: state_d = StIntOut;
            SYS_PRINT_STR: begin
              ptr_d   = bus.a0;
              cnt_d   = '0;
              state_d = StRdReq;
            end
            SYS_EXIT: state_d = StHalt;
            default:  state_d = StDone; // sbrk resolves in DONE; unknown codes are no-ops
          endcase
        end
      end
      StIntOut: begin
        int_valid = 1'b1;
        int_data  = bus.a0;
        if (bus.int_ready) state_d = StDone;
      end
      StRdReq: begin
        mem_req  = 1'b1;
        mem_addr = {ptr_q[31:2], 2'b00};
        if (bus.mem_gnt) state_d = StRdWait;
      end
      StRdWait: begin
        word_d  = bus.mem_rdata;
        state_d = StEmit;
      end
      StEmit: begin
        if (cur_byte == 8'd0) begin
          state_d = StDone;
        end else begin
          chr_valid = 1'b1;
          chr_data  = cur_byte;
          if (bus.chr_ready) begin
            ptr_d = ptr_q + 32'd1;
            cnt_d = cnt_inc;
            if (cnt_inc == CntW'(MAX_STR)) begin
              state_d = StDone;
            end else if (ptr_q[1:0] == 2'b11) begin
              state_d = StRdReq;
            end
          end
        end
      end
      StDone: begin
        sys_done = 1'b1;
        if (code_q == SYS_SBRK) begin
          heap_commit = 1'b1;
          v0_we       = 1'b1;
        end
        state_d = StIdle;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      code_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  assign bus.stall     = (bus.sys_req & ~sys_done) | (state_q == StHalt);
  assign bus.sys_done  = sys_done;
  assign bus.v0_we     = v0_we;
  assign bus.v0_wdata  = v0_we ? heap_result : 32'd0;
  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = mem_addr;
  assign bus.chr_valid = chr_valid;
  assign bus.chr_data  = chr_data;
  assign bus.int_valid = int_valid;
  assign bus.int_data  = int_data;
  assign bus.halted    = (state_q == StHalt);

endmodule

// File: tb/tb_syscall_sequencer.sv
module tb_syscall_sequencer;

  localparam logic [31:0] HEAP_BASE  = 32'h1000_0000;
  localparam logic [31:0] HEAP_SIZE  = 32'h0000_00fc;
  localparam int unsigned TB_MAX_STR = 8;
  localparam int          BUDGET     = 300;

  logic clk = 1'b0;
  logic reset;

  syscall_sequencer_if bus ();

  syscall_sequencer #(
    .HEAP_BASE (HEAP_BASE),
    .HEAP_SIZE (HEAP_SIZE),
    .MAX_STR   (TB_MAX_STR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard queues and models
  logic [7:0]  exp_chr[$];
  logic [31:0] exp_int[$];
  logic [32:0] exp_v0[$];
  logic [31:0] mem[int unsigned];
  logic [31:0] heap_m;

  int chr_mode;  // 0 always ready, 1 toggling, 2 never ready
  int int_delay;
  int gnt_delay;
  int n_reads;

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    int unsigned k;
    k = int'(addr[31:2]);
    if (mem.exists(k)) return mem[k];
    return 32'd0;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] addr);
    logic [31:0] w;
    w = mem_rd(addr);
    case (addr[1:0])
      2'd0: return w[31:24];
      2'd1: return w[23:16];
      2'd2: return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // Queues the expected characters of a string and returns the expected word-read count.
  function automatic int push_string(input logic [31:0] start);
    logic [31:0] p;
    logic [7:0]  b;
    int          cnt;
    int          reads;
    p = start;
    cnt = 0;
    reads = 1;
    forever begin
      b = mem_byte(p);
      if (b == 8'd0) break;
      exp_chr.push_back(b);
      cnt++;
      p = p + 32'd1;
      if (cnt == int'(TB_MAX_STR)) break;
      if (p[1:0] == 2'b00) reads++;
    end
    return reads;
  endfunction

  // Memory responder: grant after gnt_delay cycles, data valid the cycle after grant.
  logic        gnt_prev;
  logic [31:0] addr_prev;
  int          gnt_wait;
  initial begin
    bus.mem_gnt = 1'b0;
    bus.mem_rdata = 32'd0;
    gnt_prev = 1'b0;
    addr_prev = 32'd0;
    gnt_wait = 0;
    forever begin
      @(negedge clk);
      #1;
      bus.mem_rdata = gnt_prev ? mem_rd(addr_prev) : 32'hDEAD_BEEF;
      gnt_prev = 1'b0;
      if (bus.mem_req) begin
        if (gnt_wait >= gnt_delay) begin
          check("mem_align", {30'd0, bus.mem_addr[1:0]}, 32'd0);
          bus.mem_gnt = 1'b1;
          gnt_prev = 1'b1;
          addr_prev = bus.mem_addr;
          gnt_wait = 0;
          n_reads++;
        end else begin
          bus.mem_gnt = 1'b0;
          gnt_wait++;
        end
      end else begin
        bus.mem_gnt = 1'b0;
        gnt_wait = 0;
      end
    end
  end

  // Character sink
  logic       chr_pend;
  logic       chr_tog;
  logic [7:0] chr_last;
  initial begin
    bus.chr_ready = 1'b0;
    chr_pend = 1'b0;
    chr_tog = 1'b0;
    chr_last = 8'd0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.chr_valid) begin
        if (chr_pend) check("chr_stable", {24'd0, bus.chr_data}, {24'd0, chr_last});
        chr_last = bus.chr_data;
        case (chr_mode)
          0: bus.chr_ready = 1'b1;
          1: bus.chr_ready = chr_tog;
          default: bus.chr_ready = 1'b0;
        endcase
        chr_tog = ~chr_tog;
        if (bus.chr_ready) begin
          if (exp_chr.size() == 0) check("chr_extra", {24'd0, bus.chr_data}, 32'd0);
          else check("chr_data", {24'd0, bus.chr_data}, {24'd0, exp_chr.pop_front()});
          chr_pend = 1'b0;
        end else begin
          chr_pend = 1'b1;
        end
      end else begin
        bus.chr_ready = 1'b0;
        chr_pend = 1'b0;
      end
    end
  end

  // Integer sink
  int          int_seen;
  logic [31:0] int_last;
  initial begin
    bus.int_ready = 1'b0;
    int_seen = 0;
    int_last = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.int_valid) begin
        if (int_seen > 0) check("int_stable", bus.int_data, int_last);
        int_last = bus.int_data;
        bus.int_ready = (int_seen >= int_delay);
        if (bus.int_ready) begin
          if (exp_int.size() == 0) check("int_extra", bus.int_data, 32'd0);
          else check("int_data", bus.int_data, exp_int.pop_front());
          int_seen = 0;
        end else begin
          int_seen++;
        end
      end else begin
        bus.int_ready = 1'b0;
        int_seen = 0;
      end
    end
  end

  task automatic do_sys(input logic [31:0] code, input logic [31:0] arg);
    logic [31:0] n;
    logic [32:0] e;
    int          exp_reads;
    bit          got;
    exp_reads = 0;
    @(negedge clk);
    bus.v0 = code;
    bus.a0 = arg;
    bus.sys_req = 1'b1;
    if (code == 32'd9) begin
      n = (arg + 32'd3) & ~32'd3;
      if (({1'b0, heap_m} + {1'b0, n}) <= ({1'b0, HEAP_BASE} + {1'b0, HEAP_SIZE})) begin
        exp_v0.push_back({1'b1, heap_m});
        heap_m = heap_m + n;
      end else begin
        exp_v0.push_back({1'b1, 32'hFFFF_FFFF});
      end
    end else begin
      exp_v0.push_back({1'b0, 32'd0});
    end
    if (code == 32'd1) exp_int.push_back(arg);
    if (code == 32'd4) begin
      exp_reads = push_string(arg);
      n_reads = 0;
    end
    #1;
    check("stall_req", {31'd0, bus.stall}, 32'd1);
    got = 1'b0;
    for (int i = 0; i < BUDGET && !got; i++) begin
      @(negedge clk);
      #3;
      if (bus.sys_done) begin
        got = 1'b1;
        e = exp_v0.pop_front();
        check("v0_we", {31'd0, bus.v0_we}, {31'd0, e[32]});
        if (e[32]) check("v0_wdata", bus.v0_wdata, e[31:0]);
        bus.sys_req = 1'b0;
      end
    end
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(exp_v0.pop_front());
      bus.sys_req = 1'b0;
    end
    @(negedge clk);
    #3;
    check("done_pulse", {31'd0, bus.sys_done}, 32'd0);
    check("stall_after", {31'd0, bus.stall}, 32'd0);
    check("heap_ptr", bus.heap_ptr, heap_m);
    if (code == 32'd1) check("int_left", exp_int.size(), 32'd0);
    if (code == 32'd4) begin
      check("chr_left", exp_chr.size(), 32'd0);
      check("mem_reads", n_reads, exp_reads);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.sys_done}, 32'd0);
    check({tag, "_memreq"}, {31'd0, bus.mem_req}, 32'd0);
    check({tag, "_chrv"}, {31'd0, bus.chr_valid}, 32'd0);
    check({tag, "_intv"}, {31'd0, bus.int_valid}, 32'd0);
    check({tag, "_v0we"}, {31'd0, bus.v0_we}, 32'd0);
    check({tag, "_halted"}, {31'd0, bus.halted}, 32'd0);
    check({tag, "_heap"}, bus.heap_ptr, HEAP_BASE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    reset = 1'b1;
    bus.sys_req = 1'b0;
    bus.v0 = 32'd0;
    bus.a0 = 32'd0;
    chr_mode = 0;
    int_delay = 0;
    gnt_delay = 0;
    n_reads = 0;
    heap_m = HEAP_BASE;
    mem[32'h00 >> 2] = 32'h0000_4142;  // "\0\0AB"
    mem[32'h04 >> 2] = 32'h4300_2E2E;  // "C\0.."
    mem[32'h20 >> 2] = 32'h4869_2178;  // "Hi!x"
    mem[32'h24 >> 2] = 32'h797A_0000;  // "yz\0\0"
    mem[32'h40 >> 2] = 32'h6162_6364;  // unterminated run
    mem[32'h44 >> 2] = 32'h6566_6768;
    mem[32'h48 >> 2] = 32'h696A_6B6C;
    mem[32'h60 >> 2] = 32'h0041_4243;  // empty string

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    check_idle_outputs("reset");

    int_delay = 3;
    do_sys(32'd1, 32'hFFFF_FFFB);  // -5 with a slow sink
    int_delay = 0;
    do_sys(32'd1, 32'h7FFF_FFFF);

    do_sys(32'd4, 32'h0000_0002);
    gnt_delay = 4;
    chr_mode = 1;
    do_sys(32'd4, 32'h0000_0020);
    gnt_delay = 0;
    chr_mode = 0;
    do_sys(32'd4, 32'h0000_0040);  // stops at MAX_STR
    do_sys(32'd4, 32'h0000_0060);  // NUL first

    do_sys(32'd9, 32'd5);
    do_sys(32'd9, 32'hF8);
    do_sys(32'd9, 32'd0);
    do_sys(32'd9, 32'hF4);         // lands exactly on the limit
    do_sys(32'd7, 32'h1234);       // unknown code

    // Reset while a character is waiting on a stalled sink
    chr_mode = 2;
    @(negedge clk);
    bus.v0 = 32'd4;
    bus.a0 = 32'h40;
    bus.sys_req = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    check("midstr_chrv", {31'd0, bus.chr_valid}, 32'd1);
    reset = 1'b1;
    bus.sys_req = 1'b0;
    @(negedge clk);
    #3;
    check_idle_outputs("midreset");
    reset = 1'b0;
    exp_chr.delete();
    heap_m = HEAP_BASE;
    chr_mode = 0;
    repeat (2) @(negedge clk);
    check_idle_outputs("afterreset");
    do_sys(32'd9, 32'd4);

    // exit: halted, stalled, never done
    @(negedge clk);
    bus.v0 = 32'd10;
    bus.a0 = 32'd0;
    bus.sys_req = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (bus.sys_done) dones++;
    end
    check("halt_dones", dones, 32'd0);
    check("halted", {31'd0, bus.halted}, 32'd1);
    check("halt_stall", {31'd0, bus.stall}, 32'd1);
    bus.sys_req = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    check("halt_stall_noreq", {31'd0, bus.stall}, 32'd1);
    check("halted_sticky", {31'd0, bus.halted}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #3;
    check_idle_outputs("unhalt");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
